// File: rtl/scratch_stack_ctrl_if.sv
// Command/response and status bundle for the scratch stack sequencer.
// The master issues PUSH/POP/PEEK/CLEAR commands; the slave (the
// sequencer) answers with a one-cycle response pulse and reports the
// stack fill level.
interface scratch_stack_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W:0]   count;
   logic              empty;
   logic              full;

   modport master (
      output cmd_valid, cmd_op, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, count, empty, full
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, count, empty, full
   );
endinterface

// File: rtl/scratch_stack_ctrl.sv
// Sequencer for a single-port stack RAM with registered read (1-cycle
// latency). Owns the stack pointer, serialises PUSH/POP/PEEK/CLEAR
// commands and flags overflow/underflow instead of wrapping the pointer.
module scratch_stack_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                resetn,
   scratch_stack_ctrl_if.slave bus,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   output logic                ram_wen,
   input  logic [DATA_W-1:0]   ram_rdata
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WRITE   = 2'd1;   // also used for 1-edge responses
   localparam logic [1:0] ST_RD_WAIT = 2'd2;
   localparam logic [1:0] ST_RD_CAP  = 2'd3;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_PUSH  = 2'b01;
   localparam logic [1:0] OP_POP   = 2'b10;
   localparam logic [1:0] OP_PEEK  = 2'b11;

   localparam logic [ADDR_W:0]   DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ZERO_C = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_r;
   logic [1:0]        op_r;
   logic              err_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [DATA_W-1:0] ram_wdata_r;
   logic              ram_wen_r;
   logic              rsp_valid_r;
   logic              rsp_err_r;
   logic [DATA_W-1:0] rsp_rdata_r;

   logic              accept_s;
   logic              empty_s;
   logic              full_s;

   assign empty_s  = (count_r == CNT_ZERO_C);
   assign full_s   = (count_r == DEPTH_C);
   assign accept_s = bus.cmd_valid && (state_r == ST_IDLE);

   assign bus.cmd_ready = (state_r == ST_IDLE);
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.count     = count_r;
   assign bus.empty     = empty_s;
   assign bus.full      = full_s;
   assign ram_addr      = ram_addr_r;
   assign ram_wdata     = ram_wdata_r;
   assign ram_wen       = ram_wen_r;

   // Command sequencer: accepts in IDLE, drives the RAM and issues the response pulse.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         op_r        <= OP_CLEAR;
         err_r       <= 1'b0;
         count_r     <= CNT_ZERO_C;
         ram_addr_r  <= {ADDR_W{1'b0}};
         ram_wdata_r <= {DATA_W{1'b0}};
         ram_wen_r   <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
      end else begin
         // Pulse outputs default low; ram_wen is therefore high for one cycle only.
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         ram_wen_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r <= bus.cmd_op;
                  case (bus.cmd_op)
                     OP_PUSH: begin
                        state_r <= ST_WRITE;
                        if (!full_s) begin
                           ram_addr_r  <= count_r[ADDR_W-1:0];
                           ram_wdata_r <= bus.cmd_wdata;
                           ram_wen_r   <= 1'b1;
                           err_r       <= 1'b0;
                        end else begin
                           err_r <= 1'b1;
                        end
                     end
                     OP_POP, OP_PEEK: begin
                        if (!empty_s) begin
                           ram_addr_r <= count_r[ADDR_W-1:0] - ADDR_ONE_C;
                           err_r      <= 1'b0;
                           state_r    <= ST_RD_WAIT;
                        end else begin
                           // Underflow: no RAM access, answer after one edge.
                           err_r   <= 1'b1;
                           state_r <= ST_WRITE;
                        end
                     end
                     OP_CLEAR: begin
                        count_r <= CNT_ZERO_C;
                        err_r   <= 1'b0;
                        state_r <= ST_WRITE;
                     end
                     default: begin
                        state_r <= ST_IDLE;
                     end
                  endcase
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               // Single-edge completion: successful PUSH, CLEAR and all error cases.
               rsp_valid_r <= 1'b1;
               rsp_err_r   <= err_r;
               state_r     <= ST_IDLE;
               case (op_r)
                  OP_PUSH: begin
                     if (!err_r) begin
                        count_r     <= count_r + CNT_ONE_C;
                        rsp_rdata_r <= ram_wdata_r;
                     end else begin
                        rsp_rdata_r <= rsp_rdata_r;
                     end
                  end
                  OP_POP, OP_PEEK: begin
                     // Only the underflow path of a read reaches this state.
                     rsp_rdata_r <= {DATA_W{1'b0}};
                  end
                  default: begin
                     rsp_rdata_r <= rsp_rdata_r;
                  end
               endcase
            end
            ST_RD_WAIT: begin
               // RAM samples ram_addr on this edge; data is valid after it.
               state_r <= ST_RD_CAP;
            end
            ST_RD_CAP: begin
               rsp_rdata_r <= ram_rdata;
               rsp_valid_r <= 1'b1;
               state_r     <= ST_IDLE;
               if (op_r == OP_POP) begin
                  count_r <= count_r - CNT_ONE_C;
               end else begin
                  count_r <= count_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Randomised scoreboard bench for scratch_stack_ctrl with a 4-deep stack
// (ADDR_W=2) so overflow and underflow are reached often. A queue-based
// stack model predicts every response and every RAM write.
module tb_scratch_stack_ctrl;

   localparam int AW    = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_PUSH  = 2'b01;
   localparam logic [1:0] OP_POP   = 2'b10;
   localparam logic [1:0] OP_PEEK  = 2'b11;

   logic          CLK;
   logic          resetn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_wen;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] mem [DEPTH];

   scratch_stack_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

   scratch_stack_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK       (CLK),
      .resetn    (resetn),
      .bus       (ifc.slave),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wen   (ram_wen),
      .ram_rdata (ram_rdata)
   );

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            cnt;
      int            addr;
      int            due;
   } rsp_t;

   typedef struct {
      int            addr;
      logic [DW-1:0] data;
   } wr_t;

   rsp_t          exp_q [$];
   wr_t           wr_q  [$];
   logic [DW-1:0] stk   [$];
   logic [DW-1:0] last_rdata;
   int            exp_addr;
   int            cyc;
   int            errors;
   int            checks;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Behavioural single-port RAM with registered read
   always @(posedge CLK) begin
      if (ram_wen) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares RAM writes and responses against scoreboard queues
   always @(negedge CLK) begin
      if (resetn) begin
         if (ram_wen) begin
            if (wr_q.size() == 0) chk("wen_unexpected", ram_wen, 1'b0);
            else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("wr_addr", ram_addr, w.addr);
               chk("wr_data", ram_wdata, w.data);
            end
         end
         if (ifc.rsp_err && !ifc.rsp_valid) chk("err_without_valid", ifc.rsp_err, 1'b0);
         if (ifc.rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", ifc.rsp_valid, 1'b0);
            else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk("rsp_rdata", ifc.rsp_rdata, e.rdata);
               chk("rsp_err", ifc.rsp_err, e.err);
               chk("count", ifc.count, e.cnt);
               chk("empty", ifc.empty, (e.cnt == 0));
               chk("full", ifc.full, (e.cnt == DEPTH));
               chk("ram_addr", ram_addr, e.addr);
               chk("latency", cyc, e.due);
               chk("cmd_ready_with_rsp", ifc.cmd_ready, 1'b1);
            end
         end
      end
   end

   // Reference model: push expected response (and RAM write) for an accepted command
   task automatic model(input logic [1:0] op, input logic [DW-1:0] d, input int acc_cyc);
      rsp_t e;
      int   lat;
      e.err = 1'b0;
      lat   = 1;
      case (op)
         OP_PUSH: begin
            if (stk.size() < DEPTH) begin
               wr_t w;
               w.addr = stk.size();
               w.data = d;
               wr_q.push_back(w);
               exp_addr = stk.size();
               stk.push_back(d);
               last_rdata = d;
            end else e.err = 1'b1;
         end
         OP_POP, OP_PEEK: begin
            if (stk.size() == 0) begin
               e.err = 1'b1;
               last_rdata = '0;
            end else begin
               exp_addr   = stk.size() - 1;
               last_rdata = stk[$];
               if (op == OP_POP) void'(stk.pop_back());
               lat = 2;
            end
         end
         default: stk.delete();
      endcase
      e.rdata = last_rdata;
      e.cnt   = stk.size();
      e.addr  = exp_addr;
      e.due   = acc_cyc + lat;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] op, input logic [DW-1:0] d);
      int guard;
      guard = 0;
      @(negedge CLK);
      while (!ifc.cmd_ready && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 20) chk("cmd_ready_timeout", ifc.cmd_ready, 1'b1);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = op;
      ifc.cmd_wdata = d;
      model(op, d, cyc + 1);
      @(posedge CLK);
      #1;
      // Post-acceptance changes must be ignored by the DUT.
      ifc.cmd_valid = 1'b0;
      ifc.cmd_op    = 2'($urandom_range(0, 3));
      ifc.cmd_wdata = $urandom;
   endtask

   task automatic model_reset();
      stk.delete();
      exp_q.delete();
      wr_q.delete();
      last_rdata = '0;
      exp_addr   = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int gap;
      int r;
      errors = 0;
      checks = 0;
      cyc    = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      ram_rdata     = '0;
      model_reset();
      ifc.cmd_valid = 1'b0;
      ifc.cmd_op    = OP_CLEAR;
      ifc.cmd_wdata = '0;
      resetn        = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_cmd_ready", ifc.cmd_ready, 1'b1);
      chk("rst_empty", ifc.empty, 1'b1);
      chk("rst_full", ifc.full, 1'b0);
      chk("rst_count", ifc.count, 0);
      chk("rst_ram_wen", ram_wen, 1'b0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_rsp_valid", ifc.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", ifc.rsp_rdata, 0);
      resetn = 1'b1;

      // Directed: LIFO order, PEEK, overflow, CLEAR, underflow
      issue(OP_PUSH, 32'h11); issue(OP_PUSH, 32'h22); issue(OP_PUSH, 32'h33);
      issue(OP_POP, 32'h0);   issue(OP_POP, 32'h0);   issue(OP_POP, 32'h0);
      issue(OP_PUSH, 32'hDEADBEEF); issue(OP_PEEK, 32'h0); issue(OP_PEEK, 32'h0);
      issue(OP_POP, 32'h0);
      for (int i = 1; i <= 5; i++) issue(OP_PUSH, DW'(i));
      issue(OP_POP, 32'h0);
      issue(OP_CLEAR, 32'h0);
      issue(OP_POP, 32'h0);
      issue(OP_PEEK, 32'h0);
      issue(OP_PUSH, 32'hA5A5_0001); issue(OP_PUSH, 32'hA5A5_0002);
      repeat (4) @(negedge CLK);

      // Reset in the middle of a PUSH write: write and response are abandoned
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = OP_PUSH;
      ifc.cmd_wdata = 32'hBAD0_BAD0;
      @(posedge CLK);
      #1;
      ifc.cmd_valid = 1'b0;
      chk("midrst_wen_before", ram_wen, 1'b1);
      resetn = 1'b0;
      #1;
      chk("midrst_wen", ram_wen, 1'b0);
      chk("midrst_count", ifc.count, 0);
      chk("midrst_cmd_ready", ifc.cmd_ready, 1'b1);
      chk("midrst_rsp_valid", ifc.rsp_valid, 1'b0);
      model_reset();
      repeat (2) @(negedge CLK);
      resetn = 1'b1;
      repeat (4) @(negedge CLK);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      issue(OP_PUSH, $urandom);
         else if (r < 75) issue(OP_POP, $urandom);
         else if (r < 93) issue(OP_PEEK, $urandom);
         else             issue(OP_CLEAR, $urandom);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge CLK);
      end

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CLK);
      @(negedge CLK);
      chk("drain_rsp", exp_q.size(), 0);
      chk("drain_wr", wr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
